regfile_write_arbiter: RTL and testbench
========================================

// Module: regfile_write_arbiter
// PURPOSE
//  Shares the single register-file write port (RegWrite/WriteRegister/WriteData) among
//  NUM_REQ writers (e.g. ALU, load unit, multiplier, debug). Round-robin arbitration,
//  valid/ready handshake per requester, one registered write per cycle into regfile.
//  Writes targeting the hard-wired zero register are consumed but never issued.
// PARAMETERS
//  NUM_REQ     4   number of requesters (2..8)
//  DATA_WIDTH  64  write data width
//  ADDR_WIDTH  5   register index width
//  ZERO_REG    31  index of the hard-wired zero register
// PORTS
//  clk            in   1                   single clock, all state on posedge
//  reset          in   1                   asynchronous, active-high
//  hold           in   1                   1 = grant nothing this cycle
//  req_valid      in   NUM_REQ             requester i has a write pending
//  req_addr       in   NUM_REQ*ADDR_WIDTH  dest index, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//  req_data       in   NUM_REQ*DATA_WIDTH  write data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//  req_ready      out  NUM_REQ             one-hot grant, combinational from valid/ptr/hold
//  RegWrite       out  1                   to regfile RegWrite
//  WriteRegister  out  ADDR_WIDTH          to regfile WriteRegister
//  WriteData      out  DATA_WIDTH          to regfile WriteData
//  busy           out  1                   1 when any req_valid is high or RegWrite is high
// BEHAVIOUR
//  - Reset (async, any time): ptr=0, RegWrite=0, WriteRegister=0, WriteData=0.
//    An accepted-but-unissued write is dropped. req_ready=0 while reset is high.
//  - Handshake: transfer on req_valid[i] & req_ready[i] at posedge. Requester holds
//    valid/addr/data stable until transfer. Valid deasserted without transfer is legal.
//  - Arbitration: search starts at ptr, wraps mod NUM_REQ. The first valid index k gets
//    req_ready[k]=1. All other ready bits are 0. At most one bit is set.
//  - Pointer: after a transfer from k, ptr <= (k==NUM_REQ-1) ? 0 : k+1.
//    No transfer: ptr unchanged.
//  - hold=1: req_ready=0, ptr unchanged. RegWrite is 0 on the next cycle.
//  - Latency: transfer at edge N -> RegWrite=1 with addr/data from cycle N-1 during
//    cycle N..N+1 (exactly one cycle). With no transfer, RegWrite=0 next cycle.
//    WriteRegister/WriteData hold their last value when RegWrite=0.
//  - Zero register: transfer with addr==ZERO_REG is accepted and advances ptr.
//    RegWrite stays 0 next cycle (WriteRegister/WriteData unchanged).
//  - Throughput: one transfer per cycle. Back-to-back grants to different requesters.
//    A single requester that is always valid, with no other requesters valid, gets a
//    transfer every cycle.
//  - Fairness: with all NUM_REQ requesters continuously valid, each is granted exactly
//    once in every NUM_REQ consecutive cycles.
//  - Same dest from two requesters in consecutive cycles: both writes are issued in
//    grant order. The later write wins in the regfile. No merging or reordering.
// CONFIGURATION
//  REGFILE_ARB_STATS_EN defined:
//    - Adds output grant_cnt (NUM_REQ*16): per-requester transfer counter,
//      requester i at [i*16 +: 16].
//    - Counters saturate at 16'hFFFF, clear on reset, and include ZERO_REG transfers.
//    - Adds output zero_drop_cnt (16): saturating count of ZERO_REG transfers.
//  Not defined: neither port exists and no counter logic is generated.
//  Arbitration behaviour is identical in both builds.
// TESTING
//  1. Reset with all req_valid=1 -> req_ready=0, RegWrite=0. Release -> req_ready=4'b0001.
//  2. req_valid=4'b1111 for 8 cycles -> grants 0,1,2,3,0,1,2,3.
//     RegWrite=1 in every cycle from the second cycle on.
//  3. Only req1 valid, addr=5, data=64'hDEAD_BEEF -> next cycle RegWrite=1,
//     WriteRegister=5, WriteData=64'hDEAD_BEEF.
//  4. req2 addr=31, data=64'h1234 -> req_ready[2]=1, ptr->3, RegWrite stays 0.
//     With STATS: zero_drop_cnt=1, grant_cnt[2]=1.
//  5. req_valid=4'b1001, ptr=1, hold=1 for 2 cycles then 0 -> no ready during hold,
//     then req3 is granted before req0.
//  6. Assert reset asynchronously mid-cycle right after a transfer -> RegWrite=0
//     immediately and the write never reaches the regfile. ptr=0 afterwards.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Purpose : round-robin arbiter sharing one register-file write port among NUM_REQ
//           writers; the granted write is registered and issued one cycle later.
// Ports   : clk/reset (async, active-high), hold, req_valid/req_addr/req_data (packed
//           per requester), req_ready (one-hot grant), RegWrite/WriteRegister/WriteData
//           (to regfile), busy.
// Latency : transfer at edge N -> RegWrite=1 during cycle N..N+1.
// Backpressure: at most one requester sees req_ready per cycle; hold stalls everyone.
// Optional: define REGFILE_ARB_STATS_EN to add grant_cnt / zero_drop_cnt outputs.
module regfile_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 31
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          hold,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          RegWrite,
  output logic [ADDR_WIDTH-1:0]         WriteRegister,
  output logic [DATA_WIDTH-1:0]         WriteData,
  output logic                          busy
`ifdef REGFILE_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]         grant_cnt,
  output logic [15:0]                   zero_drop_cnt
`endif
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic                  rw_q, rw_d;
  logic [ADDR_WIDTH-1:0] wr_q, wr_d;
  logic [DATA_WIDTH-1:0] wd_q, wd_d;

  logic                  xfer;
  logic [PTR_W-1:0]      gnt_idx;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [PTR_W:0]        cand;
  logic                  sel_is_zero;

  // Round-robin search starting at ptr_q. cand carries one extra bit so the
  // wrap subtraction is exact for non-power-of-two NUM_REQ.
  always_comb begin
    req_ready = '0;
    xfer      = 1'b0;
    gnt_idx   = '0;
    sel_addr  = '0;
    sel_data  = '0;
    cand      = '0;
    if (!reset && !hold) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cand = {1'b0, ptr_q} + (PTR_W+1)'(i);
        if (cand >= (PTR_W+1)'(NUM_REQ)) begin
          cand = cand - (PTR_W+1)'(NUM_REQ);
        end
        if (!xfer && req_valid[cand[PTR_W-1:0]]) begin
          xfer                         = 1'b1;
          gnt_idx                      = cand[PTR_W-1:0];
          req_ready[cand[PTR_W-1:0]]   = 1'b1;
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (xfer && (gnt_idx == PTR_W'(i))) begin
          sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
          sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  assign sel_is_zero = (sel_addr == ADDR_WIDTH'(ZERO_REG));

  // Zero-register writes are accepted (pointer advances) but never issued;
  // the write-port address/data keep their previous values in that case.
  always_comb begin
    ptr_d = ptr_q;
    rw_d  = 1'b0;
    wr_d  = wr_q;
    wd_d  = wd_q;
    if (xfer) begin
      ptr_d = (gnt_idx == PTR_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
      if (!sel_is_zero) begin
        rw_d = 1'b1;
        wr_d = sel_addr;
        wd_d = sel_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
      rw_q  <= 1'b0;
      wr_q  <= '0;
      wd_q  <= '0;
    end else begin
      ptr_q <= ptr_d;
      rw_q  <= rw_d;
      wr_q  <= wr_d;
      wd_q  <= wd_d;
    end
  end

  assign RegWrite      = rw_q;
  assign WriteRegister = wr_q;
  assign WriteData     = wd_q;
  assign busy          = (|req_valid) | rw_q;

`ifdef REGFILE_ARB_STATS_EN
  logic [15:0] cnt_q [NUM_REQ];
  logic [15:0] zcnt_q;

  // Saturating counters; zero-register transfers count as grants too.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt_q[i] <= '0;
      end
      zcnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_ready[i] && (cnt_q[i] != 16'hFFFF)) begin
          cnt_q[i] <= cnt_q[i] + 16'd1;
        end
      end
      if (xfer && sel_is_zero && (zcnt_q != 16'hFFFF)) begin
        zcnt_q <= zcnt_q + 16'd1;
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
    assign grant_cnt[g*16 +: 16] = cnt_q[g];
  end
  assign zero_drop_cnt = zcnt_q;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Purpose : directed self-checking bench for regfile_write_arbiter (NUM_REQ=4).
// Ports   : none; drives the DUT from one linear initial block.
// Inputs change at negedge+1, outputs are sampled 1 ns after posedge.
module tb_regfile_write_arbiter;

  logic          clk;
  logic          reset;
  logic          hold;
  logic [3:0]    req_valid;
  logic [19:0]   req_addr;
  logic [255:0]  req_data;
  logic [3:0]    req_ready;
  logic          RegWrite;
  logic [4:0]    WriteRegister;
  logic [63:0]   WriteData;
  logic          busy;
`ifdef REGFILE_ARB_STATS_EN
  logic [63:0]   grant_cnt;
  logic [15:0]   zero_drop_cnt;
`endif

  int checks = 0;
  int errors = 0;

  regfile_write_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .hold          (hold),
    .req_valid     (req_valid),
    .req_addr      (req_addr),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .busy          (busy)
`ifdef REGFILE_ARB_STATS_EN
    ,
    .grant_cnt     (grant_cnt),
    .zero_drop_cnt (zero_drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [4:0] a, input logic [63:0] d);
    req_addr[i*5 +: 5]   = a;
    req_data[i*64 +: 64] = d;
  endtask

  task automatic after_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic after_neg();
    @(negedge clk);
    #1;
  endtask

  logic [3:0] exp_rdy;

  initial begin
    reset     = 1'b0;
    hold      = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    for (int i = 0; i < 4; i++) set_req(i, 5'(i + 1), 64'hA0 + 64'(i));

    // Reset with everybody valid: no grants, write port cleared.
    #1;
    reset     = 1'b1;
    req_valid = 4'b1111;
    #2;
    check("rst_ready", 64'(req_ready), 64'h0);
    check("rst_regwrite", 64'(RegWrite), 64'h0);
    check("rst_wreg", 64'(WriteRegister), 64'h0);
    check("rst_wdata", WriteData, 64'h0);
    check("rst_busy", 64'(busy), 64'h1);

    @(negedge clk);
    reset = 1'b0;
    #1;

    // All four continuously valid: grants 0,1,2,3,0,1,2,3.
    for (int k = 0; k < 8; k++) begin
      exp_rdy = 4'b0001 << (k % 4);
      check("rr_ready", 64'(req_ready), 64'(exp_rdy));
      after_pos();
      check("rr_regwrite", 64'(RegWrite), 64'h1);
      check("rr_wreg", 64'(WriteRegister), 64'(k % 4 + 1));
      check("rr_wdata", WriteData, 64'hA0 + 64'(k % 4));
      after_neg();
    end

    // Idle: RegWrite drops, address/data hold last values (req3).
    req_valid = 4'b0000;
    #1;
    check("idle_ready", 64'(req_ready), 64'h0);
    after_pos();
    check("idle_regwrite", 64'(RegWrite), 64'h0);
    check("idle_wreg_hold", 64'(WriteRegister), 64'h4);
    check("idle_wdata_hold", WriteData, 64'hA3);
    check("idle_busy", 64'(busy), 64'h0);
    after_neg();

    // Single requester (req1) valid for two cycles: granted every cycle.
    set_req(1, 5'd5, 64'hDEAD_BEEF);
    req_valid = 4'b0010;
    #1;
    check("solo_ready0", 64'(req_ready), 64'h2);
    after_pos();
    check("solo_regwrite0", 64'(RegWrite), 64'h1);
    check("solo_wreg", 64'(WriteRegister), 64'h5);
    check("solo_wdata", WriteData, 64'hDEAD_BEEF);
    check("solo_ready1", 64'(req_ready), 64'h2);
    after_pos();
    check("solo_regwrite1", 64'(RegWrite), 64'h1);
    after_neg();
    req_valid = 4'b0000;

    // Zero-register write from req2 (ptr=2): accepted, never issued.
    set_req(2, 5'd31, 64'h1234);
    req_valid = 4'b0100;
    #1;
    check("zero_ready", 64'(req_ready), 64'h4);
    after_pos();
    check("zero_regwrite", 64'(RegWrite), 64'h0);
    check("zero_wreg_hold", 64'(WriteRegister), 64'h5);
    check("zero_wdata_hold", WriteData, 64'hDEAD_BEEF);
`ifdef REGFILE_ARB_STATS_EN
    check("stat_zero_drop", 64'(zero_drop_cnt), 64'h1);
    // req2: two grants in the round-robin run plus this one.
    check("stat_grant2", 64'(grant_cnt[2*16 +: 16]), 64'h3);
    // req1: two round-robin grants plus two solo grants.
    check("stat_grant1", 64'(grant_cnt[1*16 +: 16]), 64'h4);
`endif
    after_neg();

    // Probe pointer (should be 3), then withdraw before the edge.
    req_valid = 4'b1111;
    #1;
    check("ptr3_probe", 64'(req_ready), 64'h8);
    req_valid = 4'b0000;
    after_pos();
    check("withdraw_regwrite", 64'(RegWrite), 64'h0);
    after_neg();

    // Grant req0 so ptr becomes 3 -> wait, ptr is 3: req0 search wraps, ptr -> 1.
    req_valid = 4'b0001;
    #1;
    check("wrap_ready", 64'(req_ready), 64'h1);
    after_pos();
    check("wrap_wreg", 64'(WriteRegister), 64'h1);
    after_neg();

    // Hold for two cycles with req0+req3 valid, ptr=1.
    req_valid = 4'b1001;
    hold      = 1'b1;
    #1;
    check("hold_ready0", 64'(req_ready), 64'h0);
    after_pos();
    check("hold_regwrite0", 64'(RegWrite), 64'h0);
    check("hold_busy", 64'(busy), 64'h1);
    after_neg();
    check("hold_ready1", 64'(req_ready), 64'h0);
    after_pos();
    check("hold_regwrite1", 64'(RegWrite), 64'h0);
    after_neg();
    hold = 1'b0;
    #1;
    check("unhold_req3_first", 64'(req_ready), 64'h8);
    after_pos();
    check("unhold_wreg", 64'(WriteRegister), 64'h4);
    check("unhold_wdata", WriteData, 64'hA3);
    after_neg();
    req_valid = 4'b0001;
    #1;
    check("unhold_req0_next", 64'(req_ready), 64'h1);
    after_pos();
    check("unhold_wreg0", 64'(WriteRegister), 64'h1);
    after_neg();

    // Same destination from req1 then req2 (ptr=1): both issued in order.
    set_req(1, 5'd7, 64'h111);
    set_req(2, 5'd7, 64'h222);
    req_valid = 4'b0110;
    #1;
    check("dup_ready1", 64'(req_ready), 64'h2);
    after_pos();
    check("dup_wdata1", WriteData, 64'h111);
    after_neg();
    req_valid = 4'b0100;
    #1;
    check("dup_ready2", 64'(req_ready), 64'h4);
    after_pos();
    check("dup_regwrite2", 64'(RegWrite), 64'h1);
    check("dup_wreg2", 64'(WriteRegister), 64'h7);
    check("dup_wdata2", WriteData, 64'h222);
    after_neg();

    // Async reset right after a transfer from req3: write is dropped.
    req_valid = 4'b1000;
    #1;
    check("arst_pre_ready", 64'(req_ready), 64'h8);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("arst_regwrite", 64'(RegWrite), 64'h0);
    check("arst_wreg", 64'(WriteRegister), 64'h0);
    check("arst_wdata", WriteData, 64'h0);
    check("arst_ready", 64'(req_ready), 64'h0);
`ifdef REGFILE_ARB_STATS_EN
    check("arst_grant_cnt", grant_cnt, 64'h0);
    check("arst_zero_cnt", 64'(zero_drop_cnt), 64'h0);
`endif
    @(negedge clk);
    reset     = 1'b0;
    req_valid = 4'b1111;
    #1;
    check("arst_ptr0", 64'(req_ready), 64'h1);
    after_pos();
    check("arst_after_wreg", 64'(WriteRegister), 64'h1);
    check("arst_after_regwrite", 64'(RegWrite), 64'h1);
    after_neg();
    req_valid = 4'b0000;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
